// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep valid-tagged pipeline register (in_* -> out_*) with flush/stall/bubble, registered occupancy and saturating stall/flush/bubble counters
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 10,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_reg_data2,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_reg_data2,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [3:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [DEPTH-1:0]  v_q, v_nx;
  logic [DATA_W-1:0] pc_q  [DEPTH];
  logic [DATA_W-1:0] alu_q [DEPTH];
  logic [DATA_W-1:0] rd2_q [DEPTH];
  logic [RD_W-1:0]   rd_q  [DEPTH];
  logic [CTRL_W-1:0] ctl_q [DEPTH];
  logic              clr, adv;
  assign clr = rst_n || flush;
  assign adv = !stall;
  always_comb begin
    v_nx = v_q;
    if (adv) begin
      for (int k = DEPTH - 1; k > 0; k--) v_nx[k] = v_q[k-1];
      v_nx[0] = in_valid;
    end
    if (clr) v_nx = '0;
  end
  always_ff @(posedge clk) begin
    v_q <= v_nx;
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        pc_q[k]  <= '0;
        alu_q[k] <= '0;
        rd2_q[k] <= '0;
        rd_q[k]  <= '0;
        ctl_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        pc_q[k]  <= pc_q[k-1];
        alu_q[k] <= alu_q[k-1];
        rd2_q[k] <= rd2_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        ctl_q[k] <= ctl_q[k-1];
      end
      pc_q[0]  <= in_valid ? in_pc : '0;
      alu_q[0] <= in_valid ? in_alu_res : '0;
      rd2_q[0] <= in_valid ? in_reg_data2 : '0;
      rd_q[0]  <= in_valid ? in_rd : '0;
      ctl_q[0] <= in_valid ? in_ctrl : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      occupancy  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      occupancy <= 4'($countones(v_nx));
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (!flush && stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!flush && !stall && !in_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
  assign out_valid     = v_q[DEPTH-1];
  assign out_pc        = pc_q[DEPTH-1];
  assign out_alu_res   = alu_q[DEPTH-1];
  assign out_reg_data2 = rd2_q[DEPTH-1];
  assign out_rd        = rd_q[DEPTH-1];
  assign out_ctrl      = ctl_q[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: table, directed and random checks of pipe_stage_chain against a queue model
module tb_pipe_stage_chain;
  logic clk = 1'b0;
  logic rst_n, flush, stall, in_valid;
  logic [31:0] in_pc, in_alu_res, in_reg_data2;
  logic [4:0] in_rd;
  logic [9:0] in_ctrl;
  logic a_v, b_v;
  logic [31:0] a_pc, a_alu, a_rd2, b_pc, b_alu, b_rd2;
  logic [4:0] a_rd, b_rd;
  logic [9:0] a_ctl, b_ctl;
  logic [3:0] a_occ, b_occ;
  logic [3:0] a_sc, a_fc, a_bc;
  logic [15:0] b_sc, b_fc, b_bc;
  always #5 clk = ~clk;
  pipe_stage_chain #(.DEPTH(3), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_pc(in_pc), .in_alu_res(in_alu_res), .in_reg_data2(in_reg_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(a_v), .out_pc(a_pc), .out_alu_res(a_alu), .out_reg_data2(a_rd2), .out_rd(a_rd), .out_ctrl(a_ctl),
    .occupancy(a_occ), .stall_cnt(a_sc), .flush_cnt(a_fc), .bubble_cnt(a_bc));
  pipe_stage_chain #(.DEPTH(2), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_pc(in_pc), .in_alu_res(in_alu_res), .in_reg_data2(in_reg_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(b_v), .out_pc(b_pc), .out_alu_res(b_alu), .out_reg_data2(b_rd2), .out_rd(b_rd), .out_ctrl(b_ctl),
    .occupancy(b_occ), .stall_cnt(b_sc), .flush_cnt(b_fc), .bubble_cnt(b_bc));
  typedef struct packed {
    logic v;
    logic [31:0] pc, alu, rd2;
    logic [4:0] rd;
    logic [9:0] ctl;
  } ent_t;
  typedef struct {
    bit f, s, v;
    logic [31:0] pc;
    bit ev;
    logic [31:0] epc;
    int eocc;
  } vec_t;
  ent_t qa[$], qb[$];
  int m_s, m_f, m_b;
  int passed = 0, total = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic drive(bit f, bit s, bit v, logic [31:0] pc);
    flush = f;
    stall = s;
    in_valid = v;
    in_pc = pc;
    in_alu_res = pc ^ 32'hA5A5_5A5A;
    in_reg_data2 = ~pc;
    in_rd = pc[6:2];
    in_ctrl = pc[11:2];
  endtask
  task automatic step();
    ent_t e;
    if (rst_n) begin
      qa.delete();
      qb.delete();
      repeat (3) qa.push_back('0);
      repeat (2) qb.push_back('0);
      m_s = 0;
      m_f = 0;
      m_b = 0;
    end else if (flush) begin
      foreach (qa[i]) qa[i] = '0;
      foreach (qb[i]) qb[i] = '0;
      m_f++;
    end else if (stall) m_s++;
    else begin
      e = '0;
      if (in_valid) begin
        e.v = 1'b1;
        e.pc = in_pc;
        e.alu = in_alu_res;
        e.rd2 = in_reg_data2;
        e.rd = in_rd;
        e.ctl = in_ctrl;
      end else m_b++;
      qa.push_front(e);
      qb.push_front(e);
      void'(qa.pop_back());
      void'(qb.pop_back());
    end
  endtask
  task automatic mcmp(string p, ent_t q[$], int sat, logic v, logic [31:0] pc, logic [31:0] alu,
                      logic [31:0] rd2, logic [4:0] rd, logic [9:0] ctl, logic [3:0] occ,
                      logic [15:0] sc, logic [15:0] fc, logic [15:0] bc);
    ent_t e;
    int n;
    e = q[q.size()-1];
    n = 0;
    foreach (q[i]) n += int'(q[i].v);
    chk({p, ".valid"}, v, e.v);
    chk({p, ".pc"}, pc, e.pc);
    chk({p, ".alu"}, alu, e.alu);
    chk({p, ".rd2"}, rd2, e.rd2);
    chk({p, ".rd"}, rd, e.rd);
    chk({p, ".ctrl"}, ctl, e.ctl);
    chk({p, ".occ"}, occ, n);
    chk({p, ".stall_cnt"}, sc, m_s > sat ? sat : m_s);
    chk({p, ".flush_cnt"}, fc, m_f > sat ? sat : m_f);
    chk({p, ".bubble_cnt"}, bc, m_b > sat ? sat : m_b);
  endtask
  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    mcmp("a", qa, 15, a_v, a_pc, a_alu, a_rd2, a_rd, a_ctl, a_occ, 16'(a_sc), 16'(a_fc), 16'(a_bc));
    mcmp("b", qb, 65535, b_v, b_pc, b_alu, b_rd2, b_rd, b_ctl, b_occ, b_sc, b_fc, b_bc);
  endtask
  task automatic do_reset();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    rst_n = 1'b0;
  endtask
  initial begin
    vec_t tbl[14];
    tbl = '{
      '{0, 0, 1, 32'h100, 0, 32'h0,   1},
      '{0, 0, 1, 32'h104, 0, 32'h0,   2},
      '{0, 0, 1, 32'h108, 1, 32'h100, 3},
      '{0, 0, 0, 32'h0,   1, 32'h104, 2},
      '{0, 0, 0, 32'h0,   1, 32'h108, 1},
      '{0, 0, 0, 32'h0,   0, 32'h0,   0},
      '{0, 0, 1, 32'h10C, 0, 32'h0,   1},
      '{0, 0, 1, 32'h110, 0, 32'h0,   2},
      '{0, 0, 1, 32'h114, 1, 32'h10C, 3},
      '{1, 1, 1, 32'h118, 0, 32'h0,   0},
      '{0, 0, 1, 32'h11C, 0, 32'h0,   1},
      '{0, 1, 1, 32'h120, 0, 32'h0,   1},
      '{0, 0, 1, 32'h120, 0, 32'h0,   2},
      '{0, 0, 0, 32'h0,   1, 32'h11C, 2}};
    rst_n = 1'b1;
    repeat (2) begin
      drive($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom);
      cyc();
    end
    chk("rst.valid", a_v, 0);
    chk("rst.pc", a_pc, 0);
    chk("rst.ctrl", a_ctl, 0);
    chk("rst.occ", a_occ, 0);
    chk("rst.cnts", {a_sc, a_fc, a_bc}, 0);
    rst_n = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].pc);
      cyc();
      chk($sformatf("tbl%0d.valid", i), a_v, tbl[i].ev);
      chk($sformatf("tbl%0d.pc", i), a_pc, tbl[i].epc);
      chk($sformatf("tbl%0d.occ", i), a_occ, tbl[i].eocc);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h300 + 32'(4 * i));
      cyc();
    end
    chk("fs.occ_before", a_occ, 3);
    drive(1'b1, 1'b1, 1'b1, 32'h30C);
    cyc();
    chk("fs.valid", a_v, 0);
    chk("fs.payload", {a_pc, a_alu, a_rd2, a_rd, a_ctl}, 0);
    chk("fs.occ", a_occ, 0);
    chk("fs.flush_cnt", a_fc, 1);
    chk("fs.stall_cnt", a_sc, 0);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h55);
    in_ctrl = 10'h3FF;
    in_rd = 5'd7;
    cyc();
    drive(1'b0, 1'b0, 1'b1, 32'h400);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 32'h404);
    cyc();
    chk("bub.valid", a_v, 0);
    chk("bub.ctrl", a_ctl, 0);
    chk("bub.rd", a_rd, 0);
    chk("bub.cnt", a_bc, 1);
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hA0);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 32'hA4);
    cyc();
    chk("st.head", b_pc, 32'hA0);
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("st.hold%0d", i), {b_v, b_pc}, {1'b1, 32'hA0});
    end
    chk("st.cnt", b_sc, 4);
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    cyc();
    chk("st.rel1", b_pc, 32'hA4);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("st.rel2", {b_v, b_pc}, {1'b1, 32'h200});
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 32'h600);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 14) chk("sat.at15", a_sc, 15);
    end
    chk("sat.a", a_sc, 15);
    chk("sat.b", b_sc, 20);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(63) == 0);
      drive($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0, $urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed-width EX/MEM pipeline register.
- Carries an instruction bundle (pc, alu result, store data, rd, control) through DEPTH register stages, each with its own valid bit.
- Supports hold (stall), squash (flush) and bubble insertion, with saturating stall/flush/bubble event counters for performance debug.
- Instantiated between any two pipeline stages; DEPTH>1 models a multi-cycle memory or retime path.

Parameters:
- DATA_W, 32, width of pc, alu result and store data fields.
- RD_W, 5, destination register index width.
- CTRL_W, 10, control signal bundle width.
- DEPTH, 1, number of register stages (legal range 1..8).
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1, sampled on posedge clk).
- flush  input  1  squash all stages.
- stall  input  1  hold all stages.
- in_valid  input  1  bundle at input is a real instruction.
- in_pc  input  DATA_W  incoming pc.
- in_alu_res  input  DATA_W  incoming alu result.
- in_reg_data2  input  DATA_W  incoming store data.
- in_rd  input  RD_W  incoming destination register.
- in_ctrl  input  CTRL_W  incoming control bundle.
- out_valid  output  1  valid of final stage.
- out_pc  output  DATA_W  final stage pc.
- out_alu_res  output  DATA_W  final stage alu result.
- out_reg_data2  output  DATA_W  final stage store data.
- out_rd  output  RD_W  final stage rd.
- out_ctrl  output  CTRL_W  final stage control.
- occupancy  output  4  count of valid stages (0..DEPTH).
- stall_cnt  output  CNT_W  cycles held by stall.
- flush_cnt  output  CNT_W  cycles with flush applied.
- bubble_cnt  output  CNT_W  invalid entries accepted at input.

Behaviour:
- Reset is synchronous and active-high. When rst_n=1 at posedge clk, every stage valid and payload clears to 0, all counters clear to 0, and occupancy reads 0. All outputs are registered, so reset values appear the cycle after the reset edge.
- Priority per cycle: rst_n > flush > stall > advance.
- flush=1: every stage valid and payload clears to 0, regardless of stall. flush_cnt increments. The input bundle is discarded.
- stall=1 with flush=0: every stage holds its valid and payload unchanged. stall_cnt increments. The input is not consumed; the producer must hold it.
- Advance (flush=0, stall=0):
  - stage0 loads the input; stage k loads stage k-1 for k=1..DEPTH-1.
  - If in_valid=1, stage0 takes pc/alu_res/reg_data2/rd/ctrl verbatim.
  - If in_valid=0, stage0 valid=0 and all stage0 payload fields are forced to 0, so a bubble never carries a nonzero ctrl or rd. bubble_cnt increments.
- Latency: a bundle accepted on an advance edge appears on out_* after exactly DEPTH advance edges. Stalled cycles add 1:1 delay. Order is preserved; no reordering, no drops except by flush.
- Outputs always mirror stage DEPTH-1 directly, with no combinational path from inputs. Invalid output slots present all-zero payload.
- occupancy is the registered population count of stage valids, updated on the same edge as the stages.
- Counters:
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - Counters are cleared only by rst_n; flush does not clear them.
  - At most one of stall_cnt and flush_cnt increments per cycle, since flush takes precedence.
- Simultaneous events:
  - flush and stall together behave as flush.
  - flush together with in_valid=1 does not count a bubble and does not capture the input.
- Reset mid-stream overrides any in-flight bundles. The first post-reset advance with in_valid=1 produces output DEPTH edges later.
- DEPTH=1 with stall tied to 0 matches the legacy EX/MEM register behaviour, plus the added valid/bubble semantics.

Test Plan:
- Reset with DEPTH=3: hold rst_n=1 for 2 cycles with random inputs -> all out_* =0, out_valid=0, occupancy=0, all counters=0.
- Latency, DEPTH=3: inject pc=0x100, 0x104, 0x108 with in_valid=1 on consecutive cycles -> out_pc=0x100 on the 3rd edge after injection, then 0x104 and 0x108 back-to-back; occupancy rises 1,2,3.
- Stall, DEPTH=2: with two entries in flight, assert stall for 4 cycles -> outputs frozen for 4 cycles, input pc=0x200 not lost once released, stall_cnt=4.
- Flush with stall: assert flush and stall together with 3 valid entries in flight -> next edge out_valid=0, all payload 0, occupancy=0, flush_cnt=1, stall_cnt unchanged.
- Bubble: drive in_valid=0 with in_ctrl=0x3FF and in_rd=7 -> after DEPTH edges out_ctrl=0, out_rd=0, out_valid=0, bubble_cnt=1.
- Saturation, CNT_W=4: hold stall for 20 cycles -> stall_cnt stops at 15 and remains 15.
